// File: rtl/pc_target_unit.sv
// Program counter with branch / jump / register-jump target generation.
// A redirect presented while stalled is captured (one deep, latest wins)
// and applied on the next enabled cycle.
module pc_target_unit #(
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       IDX_W    = 26,
    parameter int unsigned       SHIFT    = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              req,
    input  logic [1:0]        mode,
    input  logic [IDX_W-1:0]  idx,
    input  logic [15:0]       imm,
    input  logic [ADDR_W-1:0] rs_val,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_inc,
    output logic              pending,
    output logic              misalign
);

    typedef enum logic [1:0] {
        MODE_SEQ    = 2'b00,
        MODE_BRANCH = 2'b01,
        MODE_JUMP   = 2'b10,
        MODE_REG    = 2'b11
    } mode_t;

    generate
        if (IDX_W + SHIFT > ADDR_W) begin : g_bad_widths
            $error("pc_target_unit: IDX_W + SHIFT must not exceed ADDR_W");
        end
    endgenerate

    // Instruction size in bytes.
    localparam logic [ADDR_W-1:0] INC        = ADDR_W'(1) << SHIFT;
    // Clears the low SHIFT bits; all ones when SHIFT = 0.
    localparam logic [ADDR_W-1:0] LOW_MASK   = {ADDR_W{1'b1}} << SHIFT;
    // Bits of pc_inc kept by a jump; shifting by the full width yields zero,
    // which covers the empty upper-field case.
    localparam logic [ADDR_W-1:0] UPPER_MASK = {ADDR_W{1'b1}} << (IDX_W + SHIFT);

    mode_t             kind;
    logic              effective;
    logic              rs_misaligned;
    logic [ADDR_W-1:0] idx_ext;
    logic [ADDR_W-1:0] imm_ext;
    logic [ADDR_W-1:0] branch_target;
    logic [ADDR_W-1:0] jump_target;
    logic [ADDR_W-1:0] reg_target;
    logic [ADDR_W-1:0] target;
    logic [ADDR_W-1:0] stored;

    assign kind      = mode_t'(mode);
    assign pc_inc    = pc + INC;
    assign effective = req && (kind != MODE_SEQ);

    // Target computation from the current pc and the redirect fields.
    always_comb begin
        idx_ext              = '0;
        idx_ext[IDX_W-1:0]   = idx;
        imm_ext              = ADDR_W'($signed(imm));
        branch_target        = pc_inc + (imm_ext << SHIFT);
        jump_target          = (pc_inc & UPPER_MASK) | (idx_ext << SHIFT);
        reg_target           = rs_val & LOW_MASK;
        rs_misaligned        = (kind == MODE_REG) && ((rs_val & ~LOW_MASK) != '0);
        target               = '0;
        case (kind)
            MODE_BRANCH: target = branch_target;
            MODE_JUMP:   target = jump_target;
            MODE_REG:    target = reg_target;
            default:     target = '0;
        endcase
    end

    // PC advance, redirect capture while stalled, and misalign pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc       <= RESET_PC;
            pending  <= 1'b0;
            stored   <= '0;
            misalign <= 1'b0;
        end else begin
            misalign <= effective && rs_misaligned;
            if (en) begin
                pending <= 1'b0;
                if (effective) begin
                    pc <= target;
                end else if (pending) begin
                    pc <= stored;
                end else begin
                    pc <= pc_inc;
                end
            end else if (effective) begin
                stored  <= target;
                pending <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pc_target_unit.sv
// Directed bench for pc_target_unit: each step drives one cycle of inputs,
// pushes the expected post-edge state, then pops and compares after the edge.
module tb_pc_target_unit;

    logic        clk;
    logic        rst;
    logic        en;
    logic        req;
    logic [1:0]  mode;
    logic [25:0] idx;
    logic [15:0] imm;
    logic [31:0] rs_val;
    logic [31:0] pc;
    logic [31:0] pc_inc;
    logic        pending;
    logic        misalign;

    int unsigned checks = 0;
    int unsigned errors = 0;

    typedef struct {
        logic [31:0] pc;
        logic        pending;
        logic        misalign;
        string       tag;
    } exp_t;

    exp_t sb[$];

    pc_target_unit #(
        .ADDR_W  (32),
        .IDX_W   (26),
        .SHIFT   (2),
        .RESET_PC(32'h0)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .req     (req),
        .mode    (mode),
        .idx     (idx),
        .imm     (imm),
        .rs_val  (rs_val),
        .pc      (pc),
        .pc_inc  (pc_inc),
        .pending (pending),
        .misalign(misalign)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One clock cycle with the given inputs; expected state after the edge.
    task automatic cyc(input logic e, input logic r, input logic [1:0] m,
                       input logic [25:0] ix, input logic [15:0] im,
                       input logic [31:0] rs, input logic [31:0] epc,
                       input logic ep, input logic em, input string tag);
        exp_t x;
        en = e; req = r; mode = m; idx = ix; imm = im; rs_val = rs;
        sb.push_back('{pc: epc, pending: ep, misalign: em, tag: tag});
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: scoreboard empty", tag);
        end else begin
            x = sb.pop_front();
            check({x.tag, ".pc"}, pc, x.pc);
            check({x.tag, ".pending"}, {31'b0, pending}, {31'b0, x.pending});
            check({x.tag, ".misalign"}, {31'b0, misalign}, {31'b0, x.misalign});
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; req = 1'b0; mode = 2'b00;
        idx = '0; imm = '0; rs_val = '0;
        #2;
        check("reset.pc", pc, 32'h0);
        check("reset.pending", {31'b0, pending}, 32'h0);
        check("reset.misalign", {31'b0, misalign}, 32'h0);
        check("reset.pc_inc", pc_inc, 32'h4);
        #1 rst = 1'b0;

        // Stalled after reset release: pc stays 0.
        cyc(0, 0, 2'b00, '0, '0, '0, 32'h0, 0, 0, "stall0");
        // Sequential run 0 -> 4 -> 8 -> C.
        cyc(1, 0, 2'b00, '0, '0, '0, 32'h4, 0, 0, "seq1");
        cyc(1, 0, 2'b00, '0, '0, '0, 32'h8, 0, 0, "seq2");
        cyc(1, 0, 2'b00, '0, '0, '0, 32'hC, 0, 0, "seq3");

        // Branches from 0x100.
        cyc(1, 1, 2'b11, '0, '0, 32'h100, 32'h100, 0, 0, "rj100a");
        check("pc_inc@100", pc_inc, 32'h104);
        cyc(1, 1, 2'b01, '0, 16'hFFFE, '0, 32'hFC, 0, 0, "br_neg");
        cyc(1, 1, 2'b11, '0, '0, 32'h100, 32'h100, 0, 0, "rj100b");
        cyc(1, 1, 2'b01, '0, 16'h0003, '0, 32'h110, 0, 0, "br_pos");

        // Jump keeps upper bits of pc_inc.
        cyc(1, 1, 2'b11, '0, '0, 32'h4000_0010, 32'h4000_0010, 0, 0, "rj4000");
        cyc(1, 1, 2'b10, 26'h40, '0, '0, 32'h4000_0100, 0, 0, "jump");

        // pc_inc wrap at top of address space.
        cyc(1, 1, 2'b11, '0, '0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 0, 0, "rjtop");
        check("pc_inc_wrap", pc_inc, 32'h0);
        cyc(1, 0, 2'b00, '0, '0, '0, 32'h0, 0, 0, "seq_wrap");

        // Misaligned register jump, one-cycle pulse.
        cyc(1, 1, 2'b11, '0, '0, 32'h0000_0203, 32'h200, 0, 1, "rj_mis");
        cyc(1, 0, 2'b00, '0, '0, '0, 32'h204, 0, 0, "mis_end");

        // Stall capture with latest-wins.
        cyc(1, 1, 2'b11, '0, '0, 32'h20, 32'h20, 0, 0, "rj20");
        cyc(0, 1, 2'b10, 26'h20, '0, '0, 32'h20, 1, 0, "st_jump");
        cyc(0, 1, 2'b01, '0, 16'h0001, '0, 32'h20, 1, 0, "st_branch");
        cyc(0, 0, 2'b00, '0, '0, '0, 32'h20, 1, 0, "st_hold");
        cyc(1, 0, 2'b00, '0, '0, '0, 32'h28, 0, 0, "st_apply");

        // req with mode 00 is not a redirect.
        cyc(1, 1, 2'b00, 26'h3FF, 16'h7777, 32'h1234, 32'h2C, 0, 0, "req_seq_en");
        cyc(0, 1, 2'b00, 26'h3FF, 16'h7777, 32'h1234, 32'h2C, 0, 0, "req_seq_stall");

        // Misalign while stalled; then a fresh request overrides the stored one.
        cyc(0, 1, 2'b11, '0, '0, 32'h301, 32'h2C, 1, 1, "st_mis");
        cyc(0, 0, 2'b00, '0, '0, '0, 32'h2C, 1, 0, "st_mis_hold");
        cyc(1, 1, 2'b01, '0, 16'h0000, '0, 32'h30, 0, 0, "st_override");

        // Asynchronous reset discards a pending redirect.
        cyc(1, 1, 2'b11, '0, '0, 32'h40, 32'h40, 0, 0, "rj40");
        cyc(0, 1, 2'b01, '0, 16'h0005, '0, 32'h40, 1, 0, "st_pre_rst");
        en = 1'b0; req = 1'b0; mode = 2'b00;
        rst = 1'b1;
        #1;
        check("arst.pc", pc, 32'h0);
        check("arst.pending", {31'b0, pending}, 32'h0);
        check("arst.misalign", {31'b0, misalign}, 32'h0);
        #1 rst = 1'b0;
        cyc(1, 0, 2'b00, '0, '0, '0, 32'h4, 0, 0, "post_rst");

        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard: %0d entries left, expected 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_target_unit.md
PC_TARGET_UNIT -- requirements
Module: pc_target_unit

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32: width of the program counter and all address ports.
REQ-002 The block SHALL have parameter IDX_W, default 26: width of the jump index field.
REQ-003 The block SHALL have parameter SHIFT, default 2: log2 of instruction size in bytes; the left-shift applied to index and offset fields.
REQ-004 The block SHALL have parameter RESET_PC, default 0: PC value loaded on reset.
REQ-005 The block SHALL have port clk, input, 1: single clock, rising-edge active.
REQ-006 The block SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-007 The block SHALL have port en, input, 1: advance enable; 0 means stall.
REQ-008 The block SHALL have port req, input, 1: redirect request valid.
REQ-009 The block SHALL have port mode, input, 2: redirect kind; 00 none/sequential, 01 branch, 10 jump, 11 register jump.
REQ-010 The block SHALL have port idx, input, IDX_W: jump index field.
REQ-011 The block SHALL have port imm, input, 16: signed branch offset in instructions.
REQ-012 The block SHALL have port rs_val, input, ADDR_W: register-jump target.
REQ-013 The block SHALL have port pc, output, ADDR_W: registered current PC.
REQ-014 The block SHALL have port pc_inc, output, ADDR_W: combinational pc + 2^SHIFT.
REQ-015 The block SHALL have port pending, output, 1: registered flag; a captured redirect awaits en.
REQ-016 The block SHALL have port misalign, output, 1: registered one-cycle pulse for a misaligned register jump.

Function
REQ-017 A static check SHALL fail elaboration when IDX_W + SHIFT > ADDR_W.
REQ-018 pc_inc SHALL equal pc + 2^SHIFT, wrapping modulo 2^ADDR_W.
REQ-019 The branch target SHALL equal pc_inc + (sign-extend(imm) to ADDR_W << SHIFT), wrapping modulo 2^ADDR_W.
REQ-020 The jump target SHALL equal {pc_inc[ADDR_W-1:IDX_W+SHIFT], idx, SHIFT zero bits}, with the upper field empty when IDX_W + SHIFT = ADDR_W.
REQ-021 The register-jump target SHALL equal rs_val with its low SHIFT bits forced to 0.
REQ-022 A request is effective only when req=1 and mode is not 00; req=1 with mode=00 SHALL be ignored.
REQ-023 All targets SHALL be computed from the pc value in the cycle the request is presented, not the cycle it is applied.
REQ-024 When en=1 and an effective request is present, the next pc SHALL be the new target (latency 1 cycle), and pending SHALL be cleared.
REQ-025 When en=1, there is no effective request and pending=1, the next pc SHALL be the stored target, and pending SHALL be cleared.
REQ-026 When en=1, there is no effective request and pending=0, the next pc SHALL be pc_inc.
REQ-027 When en=0 and an effective request is present, pc SHALL hold, the target SHALL be stored, and pending SHALL be set to 1.
REQ-028 If pending is already 1 in the REQ-027 case, the newer request SHALL overwrite the stored target (latest wins; one-deep store).
REQ-029 When en=0 and there is no effective request, pc, pending and the stored target SHALL hold.
REQ-030 misalign SHALL pulse high for exactly the cycle after an effective mode-11 request whose rs_val[SHIFT-1:0] is nonzero, regardless of en; it is 0 otherwise.
REQ-031 With SHIFT=0, register-jump masking and misalign SHALL be disabled (misalign is always 0).

Reset
REQ-032 While rst=1, pc SHALL equal RESET_PC, pending SHALL be 0, misalign SHALL be 0, and the stored target SHALL be 0, independent of clk.
REQ-033 Assertion of rst mid-stall with pending=1 SHALL discard the stored redirect; the first edge after deassertion with en=1 SHALL give pc = RESET_PC + 2^SHIFT.

Verification
REQ-034 Sequential: reset release, en=1 for 3 cycles, defaults -> pc sequence 0, 4, 8, 0xC.
REQ-035 Branch: pc=0x100, mode=01, imm=0xFFFE, en=1 -> next pc=0xFC; with imm=0x0003 -> next pc=0x110.
REQ-036 Jump: pc=0x4000_0010, mode=10, idx=0x0000040 -> next pc=0x4000_0100; pc=0xFFFF_FFFC gives pc_inc=0 (wrap).
REQ-037 Stall capture: pc=0x20, en=0, jump request to 0x80, then a branch request (imm=1) at pc=0x20 -> pending=1 and pc holds at 0x20; en=1 -> next pc=0x28 (latest wins) and pending=0.
REQ-038 Misaligned register jump: mode=11, rs_val=0x0000_0203, en=1 -> next pc=0x200 and a misalign pulse of exactly 1 cycle.
REQ-039 Asynchronous reset: pending=1, pc=0x40, rst asserted between edges -> pc=0 and pending=0 immediately.
